// File: rtl/hex_seg_pkg.sv
// Shared definitions for the seven-segment scanner decoder: pattern table,
// FSM states and error cause codes.
package hex_seg_pkg;

  typedef enum logic [1:0] {
    S_HI  = 2'b00,
    S_MID = 2'b01,
    S_LO  = 2'b10
  } state_e;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b01;
  localparam logic [1:0] ERR_SEQUENCE = 2'b10;

  // Active-low {g,f,e,d,c,b,a} pattern for each nibble, index = nibble value.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h58, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/seg7_to_nibble.sv
// Combinational lookup of an active-low segment pattern into its hex nibble;
// legal_o is low for any pattern outside the table.
module seg7_to_nibble
  import hex_seg_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [3:0] nibble_o,
  output logic       legal_o
);

  always_comb begin
    nibble_o = 4'h0;
    legal_o  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (seg_i == SEG_TABLE[i[3:0]]) begin
        nibble_o = i[3:0];
        legal_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hex_seg_decode.sv
// Samples a multiplexed 3-digit seven-segment display, debounces each digit
// and assembles high/middle/low nibbles into a 12-bit word.
module hex_seg_decode
  import hex_seg_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [6:0]  seg_i,
  input  logic [2:0]  dig_sel_i,
  output logic [11:0] data_out_o,
  output logic        data_valid_o,
  output logic        err_o,
  output logic [1:0]  err_code_o
);

  localparam logic [3:0] CNT_LAST = 4'(STABLE_CYCLES - 1);
  localparam logic [3:0] CNT_PRE  = 4'(STABLE_CYCLES - 2);

  logic [6:0]  seg_meta_q, seg_sync_q;
  logic [2:0]  sel_meta_q, sel_sync_q;
  logic [9:0]  pair_prev_q;
  logic [3:0]  cnt_q, cnt_d;
  logic        same, one_hot, accept;
  logic [3:0]  nibble;
  logic        legal;

  state_e      state_q, state_d;
  logic [3:0]  hi_q, hi_d, mid_q, mid_d;
  logic [11:0] data_q, data_d;
  logic        valid_q, valid_d, err_q, err_d;
  logic [1:0]  code_q, code_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      seg_meta_q  <= '0;
      seg_sync_q  <= '0;
      sel_meta_q  <= '0;
      sel_sync_q  <= '0;
      pair_prev_q <= '0;
      cnt_q       <= '0;
    end else begin
      seg_meta_q  <= seg_i;
      seg_sync_q  <= seg_meta_q;
      sel_meta_q  <= dig_sel_i;
      sel_sync_q  <= sel_meta_q;
      pair_prev_q <= {sel_sync_q, seg_sync_q};
      cnt_q       <= cnt_d;
    end
  end

  // Accept fires on the edge the counter moves onto its last value, so the
  // saturated count never re-triggers until the pair changes.
  always_comb begin
    same    = ({sel_sync_q, seg_sync_q} == pair_prev_q);
    one_hot = $onehot(sel_sync_q);
    accept  = same && one_hot && (cnt_q == CNT_PRE);
    if (!same || !one_hot) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_LAST) begin
      cnt_d = cnt_q + 4'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  seg7_to_nibble u_lookup (
    .seg_i    (seg_sync_q),
    .nibble_o (nibble),
    .legal_o  (legal)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_HI;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (accept) begin
      if (!legal) begin
        state_d = S_HI;
      end else begin
        case (state_q)
          S_HI: begin
            if (sel_sync_q[2]) state_d = S_MID;
          end
          S_MID: begin
            if (sel_sync_q[1])      state_d = S_LO;
            else if (sel_sync_q[0]) state_d = S_HI;
          end
          S_LO: begin
            if (sel_sync_q[2]) state_d = S_MID;
            else               state_d = S_HI;
          end
          default: state_d = S_HI;
        endcase
      end
    end
  end

  // Illegal patterns are classified before any sequence check.
  always_comb begin
    hi_d    = hi_q;
    mid_d   = mid_q;
    data_d  = data_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    code_d  = code_q;
    if (accept) begin
      if (!legal) begin
        err_d  = 1'b1;
        code_d = ERR_ILLEGAL;
        hi_d   = '0;
        mid_d  = '0;
      end else begin
        case (state_q)
          S_HI: begin
            if (sel_sync_q[2]) hi_d = nibble;
          end
          S_MID: begin
            if (sel_sync_q[2]) begin
              hi_d = nibble;
            end else if (sel_sync_q[1]) begin
              mid_d = nibble;
            end else begin
              err_d  = 1'b1;
              code_d = ERR_SEQUENCE;
              hi_d   = '0;
              mid_d  = '0;
            end
          end
          S_LO: begin
            if (sel_sync_q[2]) begin
              hi_d = nibble;
            end else if (sel_sync_q[0]) begin
              data_d  = {hi_q, mid_q, nibble};
              valid_d = 1'b1;
            end else begin
              err_d  = 1'b1;
              code_d = ERR_SEQUENCE;
              hi_d   = '0;
              mid_d  = '0;
            end
          end
          default: begin
            hi_d  = '0;
            mid_d = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hi_q    <= '0;
      mid_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= ERR_NONE;
    end else begin
      hi_q    <= hi_d;
      mid_q   <= mid_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  assign data_out_o   = data_q;
  assign data_valid_o = valid_q;
  assign err_o        = err_q;
  assign err_code_o   = code_q;

endmodule

// File: tb/tb_hex_seg_decode.sv
// Directed bench for hex_seg_decode with a run-length based reference model
// compared against the DUT on every falling clock edge.
module tb_hex_seg_decode;

  localparam int STABLE = 4;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic [6:0]  seg = '0;
  logic [2:0]  digSel = '0;
  logic [11:0] dataOut;
  logic        dataValid, err;
  logic [1:0]  errCode;

  always #5 clk = ~clk;

  hex_seg_decode #(.STABLE_CYCLES(STABLE)) dut (
    .clk_i        (clk),
    .rst_ni       (rstN),
    .seg_i        (seg),
    .dig_sel_i    (digSel),
    .data_out_o   (dataOut),
    .data_valid_o (dataValid),
    .err_o        (err),
    .err_code_o   (errCode)
  );

  logic [6:0] segOf [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h58,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int vectorsApplied = 0;
  int miscompares = 0;
  int edgeCnt = 0;
  int validCnt = 0;
  int errCnt = 0;

  always @(posedge clk) edgeCnt++;

  task automatic checkOutput(input string name, input logic [11:0] actual, input logic [11:0] expected);
    vectorsApplied++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at edge %0d", name, actual, expected, edgeCnt);
    end
  endtask

  // Reference model: a digit is taken when the input pair has been identical
  // for STABLE consecutive samples, seen two edges late through the synchronizer.
  logic [9:0]  h1 = '0, h2 = '0, h3 = '0;
  int          runLen = 0;
  int          pos = 0;
  logic [3:0]  mHi = '0, mMid = '0;
  logic [11:0] mData = '0;
  logic        mValid = 1'b0, mErr = 1'b0;
  logic [1:0]  mCode = '0;

  task automatic modelAccept(input logic [2:0] sel, input logic [6:0] pat);
    int idx;
    int which;
    idx = -1;
    for (int i = 0; i < 16; i++) if (segOf[i] == pat) idx = i;
    if (idx < 0) begin
      mErr = 1'b1; mCode = 2'b01; pos = 0;
    end else begin
      which = sel[2] ? 0 : (sel[1] ? 1 : 2);
      if (which == 0) begin
        mHi = idx[3:0]; pos = 1;
      end else if (which == pos) begin
        if (pos == 1) begin
          mMid = idx[3:0]; pos = 2;
        end else begin
          mData = {mHi, mMid, idx[3:0]}; mValid = 1'b1; pos = 0;
        end
      end else if (pos != 0) begin
        mErr = 1'b1; mCode = 2'b10; pos = 0;
      end
    end
  endtask

  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      h1 = '0; h2 = '0; h3 = '0; runLen = 0; pos = 0;
      mHi = '0; mMid = '0; mData = '0; mValid = 1'b0; mErr = 1'b0; mCode = '0;
    end else begin
      mValid = 1'b0;
      mErr = 1'b0;
      if (h2 == h3) runLen = (runLen < 1000) ? runLen + 1 : runLen;
      else runLen = 1;
      if (runLen == STABLE && $onehot(h2[9:7])) modelAccept(h2[9:7], h2[6:0]);
      h3 = h2; h2 = h1; h1 = {digSel, seg};
    end
  end

  always @(negedge clk) begin
    checkOutput("data_out", dataOut, mData);
    checkOutput("data_valid", 12'(dataValid), 12'(mValid));
    checkOutput("err", 12'(err), 12'(mErr));
    checkOutput("err_code", 12'(errCode), 12'(mCode));
    checkOutput("valid_err_exclusive", 12'(dataValid & err), 12'h0);
    if (dataValid) validCnt++;
    if (err) errCnt++;
  end

  task automatic applyStimulus(input logic [2:0] sel, input logic [6:0] pat, input int cycles);
    digSel = sel;
    seg = pat;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic clearCounts();
    validCnt = 0;
    errCnt = 0;
  endtask

  initial begin
    int kFinal;
    bit got;

    repeat (3) @(negedge clk);
    checkOutput("reset_data", dataOut, 12'h000);
    checkOutput("reset_code", 12'(errCode), 12'h0);
    checkOutput("reset_valid", 12'(dataValid), 12'h0);
    rstN = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] basic word 1-3-F");
    clearCounts();
    applyStimulus(3'b100, 7'h79, 6);
    applyStimulus(3'b010, 7'h30, 6);
    applyStimulus(3'b001, 7'h0E, 6);
    applyStimulus(3'b000, 7'h00, 8);
    checkOutput("t1_valid_count", 12'(validCnt), 12'd1);
    checkOutput("t1_data", dataOut, 12'h13F);
    checkOutput("t1_err_count", 12'(errCnt), 12'd0);

    $display("[TB] glitch during low digit");
    clearCounts();
    applyStimulus(3'b100, 7'h24, 6);
    applyStimulus(3'b010, 7'h19, 6);
    applyStimulus(3'b001, 7'h46, 3);
    applyStimulus(3'b001, 7'h7F, 2);
    digSel = 3'b001;
    seg = 7'h46;
    kFinal = edgeCnt + 1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (dataValid) got = 1'b1;
    end
    if (!got) checkOutput("t2_timeout", 12'h0, 12'h1);
    else checkOutput("t2_accept_edge", 12'(edgeCnt - kFinal), 12'd5);
    checkOutput("t2_data", dataOut, 12'h24C);
    checkOutput("t2_err_count", 12'(errCnt), 12'd0);
    applyStimulus(3'b000, 7'h00, 4);

    $display("[TB] sequence error");
    clearCounts();
    applyStimulus(3'b100, 7'h40, 6);
    applyStimulus(3'b001, 7'h40, 6);
    applyStimulus(3'b000, 7'h00, 4);
    checkOutput("t3_err_count", 12'(errCnt), 12'd1);
    checkOutput("t3_code", 12'(errCode), 12'h2);
    checkOutput("t3_data_kept", dataOut, 12'h24C);
    applyStimulus(3'b001, 7'h79, 6);
    applyStimulus(3'b000, 7'h00, 4);
    checkOutput("t3_back_in_hi", 12'(errCnt), 12'd1);
    checkOutput("t3_valid_count", 12'(validCnt), 12'd0);

    $display("[TB] illegal pattern");
    clearCounts();
    applyStimulus(3'b010, 7'h7F, 6);
    applyStimulus(3'b000, 7'h00, 4);
    checkOutput("t4_err_count", 12'(errCnt), 12'd1);
    checkOutput("t4_code", 12'(errCode), 12'h1);
    checkOutput("t4_valid_count", 12'(validCnt), 12'd0);

    $display("[TB] non one-hot digit strobes");
    clearCounts();
    applyStimulus(3'b110, 7'h79, 20);
    applyStimulus(3'b000, 7'h79, 20);
    checkOutput("t5_valid_count", 12'(validCnt), 12'd0);
    checkOutput("t5_err_count", 12'(errCnt), 12'd0);
    checkOutput("t5_code_held", 12'(errCode), 12'h1);

    $display("[TB] overwrite and restart");
    clearCounts();
    applyStimulus(3'b100, 7'h12, 6);
    applyStimulus(3'b100, 7'h02, 6);
    applyStimulus(3'b010, 7'h58, 6);
    applyStimulus(3'b100, 7'h00, 6);
    applyStimulus(3'b010, 7'h10, 6);
    applyStimulus(3'b001, 7'h08, 6);
    applyStimulus(3'b000, 7'h00, 8);
    checkOutput("t6_data", dataOut, 12'h89A);
    checkOutput("t6_valid_count", 12'(validCnt), 12'd1);
    checkOutput("t6_err_count", 12'(errCnt), 12'd0);

    $display("[TB] every table entry");
    clearCounts();
    for (int w = 0; w < 6; w++) begin
      for (int d = 0; d < 3; d++) begin
        applyStimulus(3'b100 >> d, segOf[(3 * w + d) % 16], 6);
      end
    end
    applyStimulus(3'b000, 7'h00, 8);
    checkOutput("t7_data", dataOut, 12'hF01);
    checkOutput("t7_valid_count", 12'(validCnt), 12'd6);

    $display("[TB] reset mid-word");
    applyStimulus(3'b100, 7'h79, 6);
    applyStimulus(3'b010, 7'h30, 6);
    #3 rstN = 1'b0;
    #1;
    checkOutput("t8_reset_data", dataOut, 12'h000);
    checkOutput("t8_reset_code", 12'(errCode), 12'h0);
    checkOutput("t8_reset_pulses", 12'({dataValid, err}), 12'h0);
    repeat (3) @(negedge clk);
    rstN = 1'b1;
    clearCounts();
    applyStimulus(3'b001, 7'h40, 6);
    applyStimulus(3'b000, 7'h00, 6);
    checkOutput("t8_valid_count", 12'(validCnt), 12'd0);
    checkOutput("t8_err_count", 12'(errCnt), 12'd0);
    checkOutput("t8_data", dataOut, 12'h000);

    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule

// File: doc/hex_seg_decode.md
HEX_SEG_DECODE -- requirements
Module: hex_seg_decode

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, meaning the number of consecutive identical synchronized samples needed to accept a digit (legal range 2..15).
REQ-002 SHALL have port CLK  input  1  the single system clock; all state is updated on its rising edge.
REQ-003 SHALL have port RST_N  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port SEG  input  7  segment pattern {g,f,e,d,c,b,a}, active-low (0 = lit), asynchronous to CLK.
REQ-005 SHALL have port DIG_SEL  input  3  one-hot digit strobe: bit2 = high nibble, bit1 = middle nibble, bit0 = low nibble; asynchronous to CLK.
REQ-006 SHALL have port DATA_OUT  output  12  last complete decoded word, [11:8] high, [7:4] middle, [3:0] low.
REQ-007 SHALL have port DATA_VALID  output  1  one-cycle pulse; DATA_OUT was updated on this edge.
REQ-008 SHALL have port ERR  output  1  one-cycle pulse on a decode or sequence error.
REQ-009 SHALL have port ERR_CODE  output  2  error cause, held until the next ERR: 01 = illegal pattern, 10 = sequence error.

Function
REQ-010 SHALL pass SEG and DIG_SEL through a two-flop synchronizer; all further logic SHALL use only the synchronized values.
REQ-011 SHALL decode patterns (hex of SEG) 40,79,24,30,19,12,02,58,00,10,08,03,46,21,06,0E to nibbles 0..F; every other pattern SHALL be illegal.
REQ-012 SHALL run a stability counter that clears when the synchronized {DIG_SEL,SEG} differs from the previous cycle's value, or when DIG_SEL is not one-hot, and otherwise increments, saturating.
REQ-013 SHALL generate one internal accept strobe on the cycle the counter first reaches STABLE_CYCLES-1; it SHALL NOT accept again until the pair changes.
REQ-014 Latency: an input change before edge k, held stable, SHALL be accepted at edge k+1+STABLE_CYCLES (edge k+5 at default).
REQ-015 SHALL implement FSM states S_HI, S_MID, S_LO; the reset state SHALL be S_HI.
REQ-016 In S_HI: accept of bit2 with a legal pattern SHALL store the high nibble and go to S_MID; accept of bit1 or bit0 SHALL be ignored silently.
REQ-017 In S_MID: bit1 legal SHALL store the middle nibble and go to S_LO; bit2 legal SHALL overwrite the high nibble and stay; bit0 SHALL raise sequence error and go to S_HI.
REQ-018 In S_LO: bit0 legal SHALL load DATA_OUT with {high,middle,low}, pulse DATA_VALID on that edge, and go to S_HI; bit2 legal SHALL restart as in S_HI (store high, go to S_MID); bit1 SHALL raise sequence error and go to S_HI.
REQ-019 An accepted illegal pattern in any state SHALL pulse ERR with ERR_CODE=01, discard partial nibbles, and go to S_HI; illegal-pattern classification SHALL take precedence over sequence error.
REQ-020 DATA_OUT SHALL change only with DATA_VALID; DATA_VALID and ERR SHALL never be asserted together.

Reset
REQ-021 On RST_N low, SHALL immediately force DATA_OUT=000, DATA_VALID=0, ERR=0, ERR_CODE=00, FSM=S_HI, counter=0, synchronizer flops and stored nibbles to 0.
REQ-022 Reset mid-word SHALL discard partial nibbles; after release, no accept SHALL occur for at least STABLE_CYCLES+1 edges.

Structure
REQ-023 Package hex_seg_pkg SHALL hold the 16-entry pattern table, the FSM state enumeration and the ERR_CODE constants.
REQ-024 Pattern lookup SHALL be a combinational sub-module seg7_to_nibble (inputs 7-bit pattern; outputs 4-bit nibble and legal flag).

Verification
REQ-025 Hold 100/0x79, 010/0x30, 001/0x0E, 6 cycles each -> one DATA_VALID pulse, DATA_OUT=0x13F, ERR never set.
REQ-026 Glitch SEG for 2 cycles during a digit hold -> no early accept; accept occurs 5 edges after the final change.
REQ-027 Present 100/0x40, then 001/0x40 -> ERR pulse, ERR_CODE=10, DATA_OUT unchanged, FSM in S_HI.
REQ-028 Present 010 with pattern 0x7F -> ERR pulse, ERR_CODE=01, no DATA_VALID.
REQ-029 DIG_SEL=110 or 000 held 20 cycles -> no accept, no ERR.
REQ-030 Assert RST_N low after middle digit accepted, then send 001/0x40 -> outputs at reset values, no DATA_VALID.
